trd_sched: RTL and testbench

//  Parametrised thread scheduler and PC bank for the next-generation ThreadKraken fetch stage.
//  - Holds the per-thread PC and lifecycle state for NUM_TRD hardware threads.
//  - Each cycle it picks one runnable thread round-robin and presents its thread id and PC to

---
 rtl/trd_sched.sv | 153 +++++++++++++++
 tb/tb_trd_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/trd_sched.sv
// trd_sched: round-robin thread scheduler and PC bank for the fetch stage.
// Define TRD_PRIO_EN to give thread 0 strict issue priority over the round-robin threads.
module trd_sched #(
  parameter int NUM_TRD = 8,
  parameter int TW = $clog2(NUM_TRD),
  parameter int PCW = 32,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter int MISS_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               jmp,
  input  logic [TW-1:0]      jmp_trd,
  input  logic [PCW-1:0]     jmp_pc,
  input  logic               miss,
  input  logic [TW-1:0]      miss_trd,
  input  logic [PCW-1:0]     miss_pc,
  input  logic               init,
  input  logic [PCW-1:0]     init_pc,
  input  logic               kill,
  input  logic               slp,
  input  logic               wake,
  input  logic [TW-1:0]      obj_trd,
  output logic               fetch_vld,
  output logic [TW-1:0]      trd_if,
  output logic [PCW-1:0]     pc_if,
  output logic [TW-1:0]      new_trd,
  output logic               init_ack,
  output logic               trd_of,
  output logic               trd_full,
  output logic [NUM_TRD-1:0] valid_trd,
  output logic [NUM_TRD-1:0] run_trd
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SLEEP, S_WAIT} st_t;
  st_t st [NUM_TRD];
  st_t st_n [NUM_TRD];
  logic [3:0] cnt [NUM_TRD];
  logic [3:0] cnt_n [NUM_TRD];
  logic [PCW-1:0] pc [NUM_TRD];
  logic [PCW-1:0] pc_n [NUM_TRD];
  logic [TW-1:0] ptr, sel, lo, hi, ini;
  logic [NUM_TRD-1:0] idle, hk, hm, hj, hs, hw;
  logic any, hi_v, ini_v, issue, prio;
  always_comb begin
    run_trd = '0;
    valid_trd = '0;
    idle = '0;
    hk = '0;
    hm = '0;
    hj = '0;
    hs = '0;
    hw = '0;
    for (int i = 0; i < NUM_TRD; i++) begin
      run_trd[i] = st[i] == S_RUN;
      valid_trd[i] = st[i] != S_IDLE;
      hk[i] = kill && obj_trd == TW'(i);
      hm[i] = miss && miss_trd == TW'(i);
      hj[i] = jmp && jmp_trd == TW'(i);
      hs[i] = slp && obj_trd == TW'(i);
      hw[i] = wake && obj_trd == TW'(i);
      idle[i] = st[i] == S_IDLE && !hk[i];
    end
    trd_full = &valid_trd;
  end
  // Descending scan: lowest RUN id, lowest RUN id above the pointer, lowest free id.
  always_comb begin
    lo = '0;
    hi = '0;
    ini = '0;
    any = 1'b0;
    hi_v = 1'b0;
    ini_v = 1'b0;
    for (int i = NUM_TRD - 1; i >= 0; i--) begin
      if (run_trd[i]) begin
        lo = TW'(i);
        any = 1'b1;
      end
      if (run_trd[i] && i > int'(ptr)) begin
        hi = TW'(i);
        hi_v = 1'b1;
      end
      if (idle[i]) begin
        ini = TW'(i);
        ini_v = 1'b1;
      end
    end
`ifdef TRD_PRIO_EN
    prio = run_trd[0];
`else
    prio = 1'b0;
`endif
    sel = prio ? '0 : hi_v ? hi : lo;
    issue = !stall && any;
  end
  always_comb begin
    for (int i = 0; i < NUM_TRD; i++) begin
      st_n[i] = st[i];
      cnt_n[i] = cnt[i];
      pc_n[i] = pc[i];
      if (init && ini_v && ini == TW'(i)) begin
        st_n[i] = S_RUN;
        pc_n[i] = init_pc;
      end else if (hk[i]) st_n[i] = S_IDLE;
      else if (st[i] != S_IDLE) begin
        if (hm[i]) begin
          pc_n[i] = miss_pc;
          st_n[i] = st[i] == S_SLEEP ? S_SLEEP : S_WAIT;
          cnt_n[i] = st[i] == S_SLEEP ? cnt[i] : 4'(MISS_LAT);
        end else if (hj[i]) pc_n[i] = jmp_pc;
        else if (hs[i] && st[i] != S_SLEEP) st_n[i] = S_SLEEP;
        else if (hw[i] && st[i] == S_SLEEP) st_n[i] = S_RUN;
        else if (issue && sel == TW'(i)) pc_n[i] = pc[i] + PCW'(4);
        // Back-off runs on its own clock unless a miss reloads it or the thread leaves WAIT.
        if (!hm[i] && st[i] == S_WAIT && st_n[i] == S_WAIT) begin
          st_n[i] = cnt[i] == 4'd1 ? S_RUN : S_WAIT;
          cnt_n[i] = cnt[i] - 4'd1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TRD; i++) begin
        st[i] <= (i == 0) ? S_RUN : S_IDLE;
        pc[i] <= (i == 0) ? RESET_PC : '0;
        cnt[i] <= '0;
      end
      ptr <= TW'(NUM_TRD - 1);
      fetch_vld <= 1'b0;
      trd_if <= '0;
      pc_if <= '0;
      new_trd <= '0;
      init_ack <= 1'b0;
      trd_of <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TRD; i++) begin
        st[i] <= st_n[i];
        pc[i] <= pc_n[i];
        cnt[i] <= cnt_n[i];
      end
      init_ack <= init && ini_v;
      trd_of <= init && !ini_v;
      if (init && ini_v) new_trd <= ini;
      if (!stall) fetch_vld <= any;
      if (issue) begin
        trd_if <= sel;
        pc_if <= pc[sel];
        if (!prio) ptr <= sel;
      end
    end
  end
endmodule

// File: tb/tb_trd_sched.sv
// tb_trd_sched: directed vectors with hand-computed fetch sequences for trd_sched.
module tb_trd_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, jmp = 1'b0, miss = 1'b0, init = 1'b0, kill = 1'b0, slp = 1'b0, wake = 1'b0;
  logic [2:0] jmp_trd = '0, miss_trd = '0, obj_trd = '0;
  logic [31:0] jmp_pc = '0, miss_pc = '0, init_pc = '0;
  logic fetch_vld, init_ack, trd_of, trd_full;
  logic [2:0] trd_if, new_trd;
  logic [31:0] pc_if;
  logic [7:0] valid_trd, run_trd;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  trd_sched #(.NUM_TRD(8), .PCW(32), .RESET_PC(32'h100), .MISS_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .jmp(jmp), .jmp_trd(jmp_trd), .jmp_pc(jmp_pc),
    .miss(miss), .miss_trd(miss_trd), .miss_pc(miss_pc),
    .init(init), .init_pc(init_pc), .kill(kill), .slp(slp), .wake(wake), .obj_trd(obj_trd),
    .fetch_vld(fetch_vld), .trd_if(trd_if), .pc_if(pc_if), .new_trd(new_trd),
    .init_ack(init_ack), .trd_of(trd_of), .trd_full(trd_full),
    .valid_trd(valid_trd), .run_trd(run_trd)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input string tag, input logic [2:0] t, input logic [31:0] p);
    check({tag, "_vld"}, 32'(fetch_vld), 32'd1);
    check({tag, "_trd"}, 32'(trd_if), 32'(t));
    check({tag, "_pc"}, pc_if, p);
  endtask
  initial begin
    repeat (2) cyc();
    check("rst_vld", 32'(fetch_vld), 32'd0);
    check("rst_trd", 32'(trd_if), 32'd0);
    check("rst_pc", pc_if, 32'd0);
    check("rst_new", 32'(new_trd), 32'd0);
    check("rst_ack", 32'(init_ack), 32'd0);
    check("rst_of", 32'(trd_of), 32'd0);
    check("rst_valid", 32'(valid_trd), 32'h01);
    check("rst_run", 32'(run_trd), 32'h01);
    check("rst_full", 32'(trd_full), 32'd0);
    rst_n = 1'b1;
    init = 1'b1;
    init_pc = 32'h200;
    cyc();
    check("t1_ack", 32'(init_ack), 32'd1);
    check("t1_new", 32'(new_trd), 32'd1);
    fetch("t1a", 3'd0, 32'h100);
    init = 1'b0;
    cyc();
    check("t1_ack_pulse", 32'(init_ack), 32'd0);
    fetch("t1b", 3'd1, 32'h200);
    cyc();
    fetch("t1c", 3'd0, 32'h104);
    miss = 1'b1;
    miss_trd = 3'd1;
    miss_pc = 32'h300;
    cyc();
    fetch("t1d", 3'd1, 32'h204);
    check("t3_run", 32'(run_trd), 32'h01);
    check("t3_valid", 32'(valid_trd), 32'h03);
    miss = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      fetch("t3_hold", 3'd0, 32'h108 + 32'(4 * k));
    end
    cyc();
    fetch("t3_resume", 3'd1, 32'h300);
    slp = 1'b1;
    obj_trd = 3'd1;
    cyc();
    fetch("t5_slp", 3'd0, 32'h118);
    check("t5_run", 32'(run_trd), 32'h01);
    slp = 1'b0;
    stall = 1'b1;
    repeat (2) begin
      cyc();
      fetch("t5_stall", 3'd0, 32'h118);
    end
    stall = 1'b0;
    wake = 1'b1;
    cyc();
    fetch("t5_wake", 3'd0, 32'h11c);
    check("t5_run_wake", 32'(run_trd), 32'h03);
    wake = 1'b0;
    cyc();
    fetch("t5_resume", 3'd1, 32'h304);
    init = 1'b1;
    init_pc = 32'h500;
    cyc();
    check("t4_new", 32'(new_trd), 32'd2);
    fetch("t4a", 3'd0, 32'h120);
    init = 1'b0;
    cyc();
    fetch("t4b", 3'd1, 32'h308);
    kill = 1'b1;
    jmp = 1'b1;
    obj_trd = 3'd2;
    jmp_trd = 3'd2;
    jmp_pc = 32'h400;
    cyc();
    fetch("t4_kill", 3'd2, 32'h500);
    check("t4_valid", 32'(valid_trd), 32'h03);
    check("t4_run", 32'(run_trd), 32'h03);
    kill = 1'b0;
    jmp = 1'b0;
    cyc();
    fetch("t4_after", 3'd0, 32'h124);
    check("t4_full", 32'(trd_full), 32'd0);
    init = 1'b1;
    for (int k = 2; k < 8; k++) begin
      init_pc = 32'h600 + 32'(k * 16);
      cyc();
      check("t2_ack", 32'(init_ack), 32'd1);
      check("t2_new", 32'(new_trd), 32'(k));
    end
    check("t2_full_set", 32'(trd_full), 32'd1);
    cyc();
    check("t2_of", 32'(trd_of), 32'd1);
    check("t2_noack", 32'(init_ack), 32'd0);
    check("t2_full", 32'(trd_full), 32'd1);
    check("t2_valid", 32'(valid_trd), 32'hff);
    check("t2_new_hold", 32'(new_trd), 32'd7);
    init = 1'b0;
    cyc();
    check("t2_of_pulse", 32'(trd_of), 32'd0);
    rst_n = 1'b0;
    init = 1'b1;
    kill = 1'b1;
    obj_trd = 3'd3;
    cyc();
    check("mr_valid", 32'(valid_trd), 32'h01);
    check("mr_vld", 32'(fetch_vld), 32'd0);
    check("mr_ack", 32'(init_ack), 32'd0);
    rst_n = 1'b1;
    init = 1'b0;
    obj_trd = 3'd0;
    cyc();
    fetch("k0a", 3'd0, 32'h100);
    check("k0_valid", 32'(valid_trd), 32'h00);
    kill = 1'b0;
    repeat (2) begin
      cyc();
      check("k0_novld", 32'(fetch_vld), 32'd0);
    end
    init = 1'b1;
    init_pc = 32'h700;
    cyc();
    check("k0_new", 32'(new_trd), 32'd0);
    check("k0_ack", 32'(init_ack), 32'd1);
    check("k0_still_off", 32'(fetch_vld), 32'd0);
    init = 1'b0;
    cyc();
    fetch("k0_init", 3'd0, 32'h700);
`ifdef TRD_PRIO_EN
    init = 1'b1;
    init_pc = 32'h200;
    cyc();
    fetch("t6_init", 3'd0, 32'h704);
    init = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      fetch("t6_prio", 3'd0, 32'h708 + 32'(4 * k));
    end
    slp = 1'b1;
    obj_trd = 3'd0;
    cyc();
    fetch("t6_slp", 3'd0, 32'h730);
    slp = 1'b0;
    cyc();
    fetch("t6_other", 3'd1, 32'h200);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
